// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared coin codes and debounce state encoding
package vending_pkg;

    localparam int COIN_W = 5;

    localparam logic [COIN_W-1:0] COIN_5  = 5'd5;
    localparam logic [COIN_W-1:0] COIN_10 = 5'd10;

    typedef enum logic [2:0] {
        WAIT_LOW,
        LOW,
        RISE_CHK,
        HIGH,
        FALL_CHK
    } deb_state_t;

endpackage

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - two-flop synchroniser plus debounce FSM for one coin sensor
module coin_debounce
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sense,
    output logic evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    deb_state_t    state;
    logic [CW-1:0] cnt;

    // Bring the raw sensor into the clk domain; only s2 is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sense;
            s2 <= sense;
            s2 <= s1;
        end
    end

    // The edge that moves RISE_CHK into HIGH is the one accepted insertion.
    assign evt = (state == RISE_CHK) && s2 && (cnt == CNT_LAST);

    // Debounce FSM: a level change is only believed after N stable samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_LOW;
            cnt   <= '0;
        end else begin
            case (state)
                WAIT_LOW: begin
                    if (s2) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                LOW: begin
                    if (s2) begin
                        state <= RISE_CHK;
                        cnt   <= CW'(1);
                    end
                end
                RISE_CHK: begin
                    if (!s2) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state <= FALL_CHK;
                        cnt   <= CW'(1);
                    end
                end
                FALL_CHK: begin
                    if (s2) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= WAIT_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced coin sensors, classifier and accepted-coin FIFO
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int COIN_W          = vending_pkg::COIN_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sense_5,
    input  logic                          sense_10,
    input  logic                          out_en,
    output logic [COIN_W-1:0]             coin,
    output logic                          reject,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic              ev5;
    logic              ev10;
    logic [COIN_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
        .clk   (clk),
        .rst   (rst),
        .sense (sense_5),
        .evt   (ev5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
        .clk   (clk),
        .rst   (rst),
        .sense (sense_10),
        .evt   (ev10)
    );

    // Simultaneous events are ambiguous and discarded; a full FIFO only
    // accepts a new coin if the head leaves in the same cycle.
    logic              push_req;
    logic              both;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              overflow;
    logic [COIN_W-1:0] push_val;

    assign push_req = ev5 ^ ev10;
    assign both     = ev5 & ev10;
    assign full     = (fifo_level == LW'(FIFO_DEPTH));
    assign pop      = out_en && (fifo_level != '0);
    assign push_ok  = push_req && (!full || pop);
    assign overflow = push_req && full && !pop;
    assign push_val = ev5 ? COIN_W'(COIN_5) : COIN_W'(COIN_10);

    // FIFO storage; stale entries are harmless because pointers reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= push_val;
        end
    end

    // Pointers, occupancy and the registered coin/reject outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            coin       <= '0;
            reject     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                coin   <= mem[rd_ptr];
            end else begin
                coin   <= '0;
            end
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
            reject <= both | overflow;
        end
    end

endmodule
